// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// The optional PS2_TX_FILTER_EN build adds a clock-glitch filter in ps2_clk_sync.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // Shift register carries start, 8 data, parity and stop; edge 10 presents stop.
  localparam int         FRAME_W   = 11;
  localparam logic [3:0] STOP_EDGE = 4'd10;

  function automatic logic [FRAME_W-1:0] frame_build(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ps2_clk_sync.sv
// PS2_CLK pad synchronizer with falling-edge detect; PS2_TX_FILTER_EN adds an
// 8-sample stability filter between the synchronizer and the edge detector.
module ps2_clk_sync (
  input  logic clk,
  input  logic db_rst,
  input  logic ps2_clk_in,
  output logic clk_s,
  output logic fall
);

  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_q;

  // NOTE: synchronizer and edge history reset to 1 (released line) so that
  // leaving reset never manufactures a falling edge.
  always_ff @(posedge clk or posedge db_rst) begin
    if (db_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], ps2_clk_in};
    end
  end

`ifdef PS2_TX_FILTER_EN
  logic [2:0] run_q;
  logic       filt_q;

  // A new level is taken only after 8 consecutive samples that disagree with it.
  always_ff @(posedge clk or posedge db_rst) begin
    if (db_rst) begin
      filt_q <= 1'b1;
      run_q  <= '0;
    end else if (sync_q[1] == filt_q) begin
      run_q <= '0;
    end else if (run_q == 3'd7) begin
      filt_q <= sync_q[1];
      run_q  <= '0;
    end else begin
      run_q <= run_q + 1'b1;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk or posedge db_rst) begin
    if (db_rst) begin
      lvl_q <= 1'b1;
    end else begin
      lvl_q <= lvl;
    end
  end

  assign clk_s = lvl;
  assign fall  = lvl_q & ~lvl;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, start, 8 data, odd parity,
// stop, device ACK. Build option PS2_TX_FILTER_EN enables the clock glitch filter.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       db_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int               CNT_W    = cnt_width(INHIBIT_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_s;
  logic clk_fall;
  logic [1:0] data_sync_q;
  logic data_s;

  ps2_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         edge_q, edge_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [1:0]         code_q, code_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               timeout;

  ps2_clk_sync u_clk_sync (
    .clk        (clk),
    .db_rst     (db_rst),
    .ps2_clk_in (ps2_clk_in),
    .clk_s      (clk_s),
    .fall       (clk_fall)
  );

  always_ff @(posedge clk or posedge db_rst) begin
    if (db_rst) begin
      data_sync_q <= 2'b11;
    end else begin
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end

  assign data_s  = data_sync_q[1];
  assign timeout = (cnt_q == TMO_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    edge_d  = edge_q;
    shift_d = shift_q;
    code_d  = code_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          shift_d = frame_build(tx_data);
          code_d  = ERR_NONE;
          edge_d  = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        edge_d  = '0;
        state_d = BITS;
      end
      BITS: begin
        if (clk_fall) begin
          cnt_d   = '0;
          shift_d = {1'b1, shift_q[FRAME_W-1:1]};
          edge_d  = edge_q + 1'b1;
          if (edge_d == STOP_EDGE) state_d = ACK;
        end else if (timeout) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = IDLE;
        end
      end
      ACK: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (data_s) begin
            err_d   = 1'b1;
            code_d  = ERR_NACK;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pad enables are registered from the next state so the open-drain lines never glitch.
    clk_oe_d  = (state_d == INHIBIT) || (state_d == START);
    data_oe_d = (state_d == START) || ((state_d == BITS) && !shift_d[0]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge db_rst) begin
    if (db_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      shift_q   <= '1;
      code_q    <= ERR_NONE;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      shift_q   <= shift_d;
      code_q    <= code_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign err_code    = code_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: it sends one command byte (for example 0xED "set LEDs" or 0xFF "reset") from the FPGA to the keyboard. It sits beside the keyboard decoder on the shared PS2_CLK/PS2_DATA open-drain lines and implements the full host-request frame: inhibit, start, 8 data bits, odd parity, stop, and device ACK. `busy` tells the receive path to ignore line activity while a frame is in flight.

## Interface
- `INHIBIT_CYCLES`, default 12000: clk cycles PS2_CLK is held low before the start bit (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 1500000: maximum clk cycles allowed between consecutive device falling edges, and from clock release to the first edge (15 ms).
- `clk` in 1: system clock, 100 MHz.
- `db_rst` in 1: reset, asynchronous, active-high.
- `tx_data` in 8: byte to send; sampled on accept.
- `tx_valid` in 1: request to send.
- `tx_ready` out 1: high only in IDLE; accept occurs when `tx_valid & tx_ready`.
- `ps2_clk_in` in 1: raw PS2_CLK pad input.
- `ps2_data_in` in 1: raw PS2_DATA pad input.
- `ps2_clk_oe` out 1: 1 = drive PS2_CLK low; 0 = release to Z.
- `ps2_data_oe` out 1: 1 = drive PS2_DATA low; 0 = release to Z.
- `busy` out 1: high in every state except IDLE.
- `tx_done` out 1: one-cycle pulse on successful ACK and return to line idle.
- `tx_err` out 1: one-cycle pulse on failure.
- `err_code` out 2: 01 = timeout, 10 = NACK. Holds until the next accept.

## Operation
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_done`=0, `tx_err`=0, `err_code`=00, `busy`=0, `tx_ready`=1 (combinational from IDLE).
- PS2_CLK is synchronized through 2 flops, then falling-edge detected. PS2_DATA is synchronized through 2 flops.
- Frame shift register is {stop=1, parity=~^tx_data, tx_data}, shifted LSB first. `ps2_data_oe` = ~current bit.
- IDLE: on accept, latch the frame, clear `err_code`, go to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: lasts 1 cycle with `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit 0), then go to BITS.
- BITS: `ps2_clk_oe`=0. Falling edges 1–8 present d0..d7, edge 9 presents parity, edge 10 presents stop (`ps2_data_oe`=0). After edge 10, go to ACK.
- ACK: on edge 11, sample synchronized data. 0 → WAIT_IDLE. 1 → `tx_err`, `err_code`=10, go to IDLE.
- WAIT_IDLE: when synchronized clk and data are both 1, pulse `tx_done` and go to IDLE.
- Timeout counter runs in BITS, ACK and WAIT_IDLE. It restarts on every falling edge and on entry to BITS. Reaching TIMEOUT_CYCLES → both oe=0, `tx_err`, `err_code`=01, go to IDLE.
- Edge counter is 4 bits. Counter widths are $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1).
- `tx_valid` while not IDLE is ignored; there is no queue.
- `db_rst` mid-frame releases both lines asynchronously and returns to IDLE. The partial frame is discarded and no done/err pulse is produced.

## Timing
- Accept at edge N: `ps2_clk_oe` rises at N+1 and stays high through the START cycle, i.e. INHIBIT_CYCLES+1 cycles total.
- `ps2_data_oe` rises 1 cycle before `ps2_clk_oe` falls.
- Device falling edge to `ps2_data_oe` update: 3 cycles (2 sync + 1 edge/register). This is well inside the ≥30 µs clock-low phase.
- `tx_done` and `tx_err` are registered single-cycle pulses. `busy` falls on the same edge.

## Configuration
- `PS2_TX_FILTER_EN` defined: the synchronized clock passes through an 8-sample stability filter. A level change is accepted only after 8 consecutive equal samples, so glitches under 8 cycles are ignored. Edge latency becomes 11 cycles.
- `PS2_TX_FILTER_EN` undefined: no filter; latency 3 cycles.

## Structure
- `ps2_pkg` holds:
  - state enum IDLE/INHIBIT/START/BITS/ACK/WAIT_IDLE;
  - ERR_TIMEOUT=2'b01, ERR_NACK=2'b10;
  - command constants CMD_SET_LED=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF.
- Sub-module `ps2_clk_sync`: 2-flop sync, optional filter, outputs `clk_s` and `fall` pulse.

## Test plan
- Send 0xED with a device BFM that ACKs:
  - `ps2_clk_oe` high 12001 cycles;
  - bits sampled on rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - ACK 0 → `tx_done`=1 for 1 cycle, `err_code`=00.
- Send 0x00 and the BFM returns data=1 at edge 11 → parity observed 1, `tx_err` pulse, `err_code`=10, both oe=0.
- BFM never clocks → `tx_err` exactly TIMEOUT_CYCLES cycles after BITS entry, `err_code`=01, `tx_ready`=1 next cycle.
- `tx_valid` pulsed with 0x55 during BITS of a 0xFF frame → ignored; only 0xFF bits appear and only one `tx_done`.
- `db_rst` asserted after falling edge 5 → both oe=0 with no clk edge required; `tx_ready`=1 after release; no done/err pulse.
- 3-cycle low glitch on `ps2_clk_in` during BITS:
  - `PS2_TX_FILTER_EN` defined → ignored, frame correct;
  - undefined → counted as an edge, bit order shifts, so the NACK/ACK check catches it.
